// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Brief    : Shared key indices, key count and key channel FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int N_KEYS    = 5;
    localparam int KEY_SEC   = 0;
    localparam int KEY_MIN   = 1;
    localparam int KEY_HOUR  = 2;
    localparam int KEY_CLEAR = 3;
    localparam int KEY_KEEP  = 4;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } key_state_e;

endpackage

`default_nettype wire

// File: rtl/key_channel.sv
// ============================================================================
// Module   : key_channel
// Brief    : One key: 2-flop synchroniser, tick debounce, press/repeat FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_channel
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_MS      = 20,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 100,
    parameter int ACTIVE_LOW       = 1
) (
    input  logic clk_48mhz,
    input  logic rst,
    input  logic tick_ms,
    input  logic repeat_en,
    input  logic key_raw,
    output logic key_level,
    output logic key_strobe,
    output logic key_release
);

    localparam int c_db_w     = $clog2(DEBOUNCE_MS + 1);
    localparam int c_rp_max   = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
    localparam int c_rp_w     = $clog2(c_rp_max + 1);
    localparam logic c_idle_raw = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [c_db_w-1:0] c_db_last    = c_db_w'(DEBOUNCE_MS);
    localparam logic [c_rp_w-1:0] c_rp_delay   = c_rp_w'(REPEAT_DELAY_MS - 1);
    localparam logic [c_rp_w-1:0] c_rp_period  = c_rp_w'(REPEAT_PERIOD_MS - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_q, level_d;
    logic              strobe_q, strobe_d;
    logic              release_q, release_d;
    logic [c_db_w-1:0] db_cnt_q, db_cnt_d;
    logic [c_rp_w-1:0] rp_cnt_q, rp_cnt_d;
    key_state_e        state_q, state_d;
    logic              w_raw_act;
    logic              w_flip;

    always_comb begin
        w_raw_act = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        sync1_d   = key_raw;
        sync2_d   = sync1_q;
        level_d   = level_q;
        db_cnt_d  = db_cnt_q;
        rp_cnt_d  = rp_cnt_q;
        state_d   = state_q;
        strobe_d  = 1'b0;
        release_d = 1'b0;
        w_flip    = 1'b0;

        // Level only flips after DEBOUNCE_MS+1 consecutive mismatched ticks.
        if (w_raw_act == level_q) begin
            db_cnt_d = '0;
        end else if (tick_ms) begin
            if (db_cnt_q == c_db_last) begin
                w_flip   = 1'b1;
                level_d  = w_raw_act;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + c_db_w'(1);
            end
        end

        case (state_q)
            RELEASED: begin
                if (w_flip && w_raw_act) begin
                    state_d  = HELD;
                    rp_cnt_d = '0;
                    strobe_d = 1'b1;
                end
            end
            HELD: begin
                if (w_flip) begin
                    state_d   = RELEASED;
                    rp_cnt_d  = '0;
                    release_d = 1'b1;
                end else if (tick_ms) begin
                    if (rp_cnt_q == c_rp_delay) begin
                        rp_cnt_d = '0;
                        if (repeat_en) begin
                            strobe_d = 1'b1;
                            state_d  = REPEATING;
                        end
                    end else begin
                        rp_cnt_d = rp_cnt_q + c_rp_w'(1);
                    end
                end
            end
            REPEATING: begin
                if (w_flip) begin
                    state_d   = RELEASED;
                    rp_cnt_d  = '0;
                    release_d = 1'b1;
                end else if (tick_ms) begin
                    if (rp_cnt_q == c_rp_period) begin
                        rp_cnt_d = '0;
                        strobe_d = 1'b1;
                    end else begin
                        rp_cnt_d = rp_cnt_q + c_rp_w'(1);
                    end
                end
            end
            default: begin
                state_d  = RELEASED;
                rp_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (rst) begin
            sync1_q   <= c_idle_raw;
            sync2_q   <= c_idle_raw;
            level_q   <= 1'b0;
            strobe_q  <= 1'b0;
            release_q <= 1'b0;
            db_cnt_q  <= '0;
            rp_cnt_q  <= '0;
            state_q   <= RELEASED;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            strobe_q  <= strobe_d;
            release_q <= release_d;
            db_cnt_q  <= db_cnt_d;
            rp_cnt_q  <= rp_cnt_d;
            state_q   <= state_d;
        end
    end

    assign key_level   = level_q;
    assign key_strobe  = strobe_q;
    assign key_release = release_q;

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// ============================================================================
// Module   : key_conditioner
// Brief    : 1 ms prescaler plus one debounce/auto-repeat channel per key.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_conditioner
    import clock_pkg::*;
#(
    parameter int                TICK_DIV         = 48000,
    parameter int                DEBOUNCE_MS      = 20,
    parameter int                REPEAT_DELAY_MS  = 500,
    parameter int                REPEAT_PERIOD_MS = 100,
    parameter logic [N_KEYS-1:0] REPEAT_MASK      = 5'b00111,
    parameter int                ACTIVE_LOW       = 1
) (
    input  logic              clk_48mhz,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_strobe,
    output logic [N_KEYS-1:0] key_release,
    output logic              tick_ms
);

    localparam int c_tick_w = $clog2(TICK_DIV);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

    logic [c_tick_w-1:0] presc_q, presc_d;
    logic                tick_q, tick_d;

    // Tick is registered from the next count so it is high while the count is TICK_DIV-1.
    always_comb begin
        presc_d = (presc_q == c_tick_last) ? '0 : presc_q + c_tick_w'(1);
        tick_d  = (presc_d == c_tick_last);
    end

    always_ff @(posedge clk_48mhz) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_ms = tick_q;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_channel #(
            .DEBOUNCE_MS      (DEBOUNCE_MS),
            .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
            .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS),
            .ACTIVE_LOW       (ACTIVE_LOW)
        ) u_key_channel (
            .clk_48mhz   (clk_48mhz),
            .rst         (rst),
            .tick_ms     (tick_q),
            .repeat_en   (REPEAT_MASK[gi]),
            .key_raw     (key_raw[gi]),
            .key_level   (key_level[gi]),
            .key_strobe  (key_strobe[gi]),
            .key_release (key_release[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
// Module   : tb_key_conditioner
// Brief    : Directed and random stimulus against a tick-counting key model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_key_conditioner;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 10;
    localparam int RP = 4;

    logic       clk_48mhz = 1'b0;
    logic       rst;
    logic [4:0] key_raw;
    logic [4:0] key_level;
    logic [4:0] key_strobe;
    logic [4:0] key_release;
    logic       tick_ms;

    key_conditioner #(
        .TICK_DIV         (TD),
        .DEBOUNCE_MS      (DB),
        .REPEAT_DELAY_MS  (RD),
        .REPEAT_PERIOD_MS (RP),
        .REPEAT_MASK      (5'b00111),
        .ACTIVE_LOW       (1)
    ) dut (
        .clk_48mhz   (clk_48mhz),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_strobe  (key_strobe),
        .key_release (key_release),
        .tick_ms     (tick_ms)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int checks = 0;
    int errors = 0;

    // Reference model: pressed level, consecutive mismatched ticks, ticks held.
    logic [4:0] mask_v = 5'b00111;
    logic [4:0] m_s1, m_s2, m_level, m_strobe, m_release;
    logic       m_tick;
    int         m_mism [5];
    int         m_held [5];
    int         cyc;

    int n_strobe [5];
    int n_rel    [5];
    int n_tick;
    int n_misalign;

    function automatic void model_edge();
        logic pre_tick;
        logic flipped;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_strobe = '0; m_release = '0;
            m_tick = 1'b0;
            cyc = 0;
            for (int k = 0; k < 5; k++) begin
                m_mism[k] = 0;
                m_held[k] = 0;
            end
            return;
        end
        pre_tick  = m_tick;
        m_strobe  = '0;
        m_release = '0;
        for (int k = 0; k < 5; k++) begin
            flipped = 1'b0;
            if (m_s2[k] != m_level[k]) begin
                if (pre_tick) begin
                    m_mism[k]++;
                    if (m_mism[k] == DB + 1) begin
                        m_level[k] = m_s2[k];
                        m_mism[k]  = 0;
                        flipped    = 1'b1;
                        if (m_s2[k]) begin
                            m_strobe[k] = 1'b1;
                            m_held[k]   = 0;
                        end else begin
                            m_release[k] = 1'b1;
                        end
                    end
                end
            end else begin
                m_mism[k] = 0;
            end
            if (!flipped && m_level[k] && pre_tick && mask_v[k]) begin
                m_held[k]++;
                if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RP == 0))
                    m_strobe[k] = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = ~key_raw;
        cyc++;
        m_tick = (cyc % TD == TD - 1);
    endfunction

    task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 5; k++) begin
            n_strobe[k] = 0;
            n_rel[k]    = 0;
        end
        n_tick     = 0;
        n_misalign = 0;
    endtask

    task automatic step();
        @(posedge clk_48mhz);
        model_edge();
        #1;
        check5("level", key_level, m_level);
        check5("strobe", key_strobe, m_strobe);
        check5("release", key_release, m_release);
        check5("tick", {4'b0, tick_ms}, {4'b0, m_tick});
        check5("strobe_and_release", key_strobe & key_release, 5'b0);
        for (int k = 0; k < 5; k++) begin
            n_strobe[k] += int'(key_strobe[k]);
            n_rel[k]    += int'(key_release[k]);
        end
        n_tick += int'(tick_ms);
        if (key_strobe[0] != key_strobe[2]) n_misalign++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_level(input int k, input logic val, input int budget);
        int n;
        n = 0;
        while (key_level[k] !== val && n < budget) begin
            step();
            n++;
        end
        check5("wait_level", {4'b0, key_level[k]}, {4'b0, val});
    endtask

    initial begin
        rst     = 1'b1;
        key_raw = 5'b11111;
        clear_counts();
        run(3);

        // Idle after reset
        rst = 1'b0;
        clear_counts();
        run(200);
        check_int("idle_ticks", n_tick, 50);
        check_int("idle_strobes", n_strobe[0] + n_strobe[1] + n_strobe[2] + n_strobe[3] + n_strobe[4], 0);

        // Clean press and long hold of key 0
        key_raw[0] = 1'b0;
        clear_counts();
        wait_level(0, 1'b1, 40);
        check_int("press_strobe", n_strobe[0], 1);
        clear_counts();
        run(240);
        check_int("repeat_count", n_strobe[0], 13);
        key_raw[0] = 1'b1;
        clear_counts();
        wait_level(0, 1'b0, 40);
        check_int("release_pulse", n_rel[0], 1);
        run(20);

        // Bounce on key 1
        clear_counts();
        repeat (13) begin
            key_raw[1] = ~key_raw[1];
            run(3);
        end
        key_raw[1] = 1'b0;
        run(1);
        check_int("bounce_no_strobe", n_strobe[1], 0);
        run(40);
        check_int("bounce_one_strobe", n_strobe[1], 1);
        key_raw[1] = 1'b1;
        run(30);

        // Non-repeat key 3
        key_raw[3] = 1'b0;
        clear_counts();
        run(220);
        check_int("clear_one_strobe", n_strobe[3], 1);
        key_raw[3] = 1'b1;
        clear_counts();
        run(30);
        check_int("clear_one_release", n_rel[3], 1);
        check_int("clear_no_strobe_after", n_strobe[3], 0);

        // Simultaneous keys 0 and 2
        key_raw = 5'b11010;
        clear_counts();
        run(120);
        check_int("aligned_count", n_strobe[0], n_strobe[2]);
        check_int("aligned_cycles", n_misalign, 0);
        key_raw = 5'b11111;
        run(30);

        // Reset while key 2 is repeating
        key_raw[2] = 1'b0;
        run(100);
        rst = 1'b1;
        clear_counts();
        step();
        check5("rst_outputs", key_level | key_strobe | key_release, 5'b0);
        rst = 1'b0;
        run(50);
        check_int("rst_fresh_strobe", n_strobe[2], 1);
        check_int("rst_no_release", n_rel[2], 0);
        key_raw[2] = 1'b1;
        run(30);

        // Random patterns with occasional reset
        repeat (60) begin
            key_raw = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 19) == 0);
            step();
            rst = 1'b0;
            run($urandom_range(1, 40));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
